// File: rtl/ofmap_writeback_if.sv
// rtl/ofmap_writeback_if.sv - beat input and SRAM write bundle for ofmap_writeback
interface ofmap_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int act_bw  = 4,
  parameter int addr_bw = 8
);
  logic                     i_valid;
  logic [col*psum_bw-1:0]   in;
  logic                     o_wen;
  logic [addr_bw-1:0]       o_addr;
  logic [col*act_bw-1:0]    o_data;

  modport master (output i_valid, output in, input o_wen, input o_addr, input o_data);
  modport slave  (input i_valid, input in, output o_wen, output o_addr, output o_data);
endinterface

// File: rtl/ofmap_writeback.sv
// rtl/ofmap_writeback.sv - ReLU, shift-requantize and saturate psums, write one tile to ofmap SRAM
module ofmap_writeback #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int act_bw  = 4,
  parameter int nij_len = 36,
  parameter int addr_bw = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_bw-1:0]  base_addr,
  input  logic                relu_en,
  input  logic [3:0]          shift,
  ofmap_writeback_if.slave    bus,
  output logic                busy,
  output logic                done,
  output logic [15:0]         sat_cnt,
  output logic                drop
);
  localparam int cnt_bw = $clog2(nij_len + 1);
  localparam int nsat_bw = $clog2(col + 1);
  localparam logic signed [psum_bw-1:0] act_max = psum_bw'(2 ** (act_bw - 1) - 1);
  localparam logic signed [psum_bw-1:0] act_min = psum_bw'(-(2 ** (act_bw - 1)));

  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [cnt_bw-1:0]    beat_cnt;
  logic [addr_bw-1:0]   base_l;
  logic                 relu_l;
  logic [3:0]           shift_l;
  logic                 accept, last_beat, start_ok;
  logic [col*act_bw-1:0] q_data;
  logic [nsat_bw-1:0]   n_sat;
  logic [16:0]          sat_sum;

  assign accept    = (state == ARMED) && bus.i_valid;
  assign last_beat = accept && (beat_cnt == cnt_bw'(nij_len - 1));
  assign start_ok  = (state == IDLE) && start;
  assign sat_sum   = {1'b0, sat_cnt} + 17'(n_sat);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = ARMED;
      ARMED: begin
        busy = 1'b1;
        if (last_beat) state_nxt = FLUSH;
      end
      FLUSH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-column requantization; n_sat counts the clamped lanes of this beat
  always_comb begin
    logic signed [psum_bw-1:0] x;
    logic signed [psum_bw-1:0] y;
    x      = '0;
    y      = '0;
    q_data = '0;
    n_sat  = '0;
    for (int j = 0; j < col; j++) begin
      x = bus.in[j*psum_bw +: psum_bw];
      if (relu_l && x[psum_bw-1]) x = '0;
      y = x >>> shift_l;
      if (y > act_max) begin
        y     = act_max;
        n_sat = n_sat + nsat_bw'(1);
      end else if (y < act_min) begin
        y     = act_min;
        n_sat = n_sat + nsat_bw'(1);
      end
      q_data[j*act_bw +: act_bw] = y[act_bw-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_l      <= '0;
      relu_l      <= 1'b0;
      shift_l     <= '0;
      beat_cnt    <= '0;
      sat_cnt     <= '0;
      drop        <= 1'b0;
      bus.o_wen   <= 1'b0;
      bus.o_addr  <= '0;
      bus.o_data  <= '0;
    end else begin
      bus.o_wen <= accept;
      if (accept) begin
        bus.o_addr <= base_l + addr_bw'(beat_cnt);
        bus.o_data <= q_data;
        sat_cnt    <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
        beat_cnt   <= beat_cnt + cnt_bw'(1);
      end
      if (start_ok) begin
        base_l   <= base_addr;
        relu_l   <= relu_en;
        shift_l  <= shift;
        beat_cnt <= '0;
        sat_cnt  <= '0;
        drop     <= 1'b0;
      end
      // A beat outside ARMED belongs to no tile; flagging it wins over a same-cycle clear
      if (bus.i_valid && (state != ARMED)) drop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ofmap_writeback.sv
// tb/tb_ofmap_writeback.sv - randomized directed bench for ofmap_writeback with arithmetic reference model
module tb_ofmap_writeback;
  localparam int COL = 8, PBW = 16, ABW = 4, NIJ = 36, AW = 8;
  localparam int QMAX = (1 << (ABW - 1)) - 1;
  localparam int QMIN = -(1 << (ABW - 1));

  logic clk = 1'b0;
  logic reset, start, relu_en, busy, done, drop;
  logic [AW-1:0] base_addr;
  logic [3:0] shift;
  logic [15:0] sat_cnt;

  ofmap_writeback_if #(.col(COL), .psum_bw(PBW), .act_bw(ABW), .addr_bw(AW)) bus ();

  ofmap_writeback #(.col(COL), .psum_bw(PBW), .act_bw(ABW), .nij_len(NIJ), .addr_bw(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .relu_en(relu_en),
    .shift(shift), .bus(bus), .busy(busy), .done(done), .sat_cnt(sat_cnt), .drop(drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]      addr;
    logic [COL*ABW-1:0] data;
    logic [15:0]        sat;
    logic               done;
    logic               busy;
  } wr_t;
  typedef int beat_t[COL];

  wr_t   wq[$];
  beat_t beats[$];
  int    done_cnt = 0;
  int    done_orphan = 0;
  int    total = 0;
  int    bad = 0;

  always @(negedge clk) begin
    if (bus.o_wen) wq.push_back('{bus.o_addr, bus.o_data, sat_cnt, done, busy});
    if (done) done_cnt++;
    if (done && !bus.o_wen) done_orphan++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Floor division by 2^sh done with integer arithmetic, then clamp to the activation range
  function automatic int quant(input int x, input bit relu, input int sh, output bit sat);
    int v, d, y;
    v = (relu && x < 0) ? 0 : x;
    d = 1 << sh;
    if (v >= 0) y = v / d;
    else        y = -((-v + d - 1) / d);
    sat = 1'b0;
    if (y > QMAX)      begin y = QMAX; sat = 1'b1; end
    else if (y < QMIN) begin y = QMIN; sat = 1'b1; end
    return y;
  endfunction

  function automatic logic [COL*PBW-1:0] pack(input beat_t b);
    logic [COL*PBW-1:0] v;
    for (int j = 0; j < COL; j++) v[j*PBW +: PBW] = 16'(b[j]);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n, input int span);
    beat_t b;
    beats.delete();
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < COL; j++)
        b[j] = (span == 0) ? int'($signed(16'($urandom))) : int'($urandom_range(2 * span, 0)) - span;
      beats.push_back(b);
    end
  endtask

  task automatic run_tile(input string name, input logic [AW-1:0] base, input bit relu, input int sh,
                          input int gap_max, input int mid_start_at, input bit flush_poke);
    int w0, d0, o0, n, sat_run, q;
    bit s;
    logic [COL*ABW-1:0] exp_data;
    logic [AW-1:0] exp_addr;
    w0 = wq.size();
    d0 = done_cnt;
    o0 = done_orphan;
    start = 1'b1; base_addr = base; relu_en = relu; shift = 4'(sh);
    tick();
    start = 1'b0; base_addr = ~base; relu_en = ~relu; shift = 4'($urandom);
    check({name, ".busy_after_start"}, busy, 1);
    check({name, ".drop_cleared"}, drop, 0);
    for (int k = 0; k < beats.size(); k++) begin
      repeat ($urandom_range(gap_max, 0)) tick();
      if (k == mid_start_at) begin start = 1'b1; base_addr = base + 8'h40; end
      bus.i_valid = 1'b1;
      bus.in = pack(beats[k]);
      tick();
      bus.i_valid = 1'b0;
      start = 1'b0;
    end
    if (flush_poke) begin
      start = 1'b1; base_addr = base + 8'h11; bus.i_valid = 1'b1;
      tick();
      start = 1'b0; bus.i_valid = 1'b0;
      check({name, ".flush_start_ignored"}, busy, 0);
      check({name, ".flush_drop"}, drop, 1);
    end
    repeat (3) tick();
    n = wq.size() - w0;
    check({name, ".wr_count"}, n, beats.size());
    sat_run = 0;
    for (int k = 0; k < beats.size() && k < n; k++) begin
      for (int j = 0; j < COL; j++) begin
        q = quant(beats[k][j], relu, sh, s);
        exp_data[j*ABW +: ABW] = 4'(q);
        sat_run += s;
      end
      if (sat_run > 16'hFFFF) sat_run = 16'hFFFF;
      exp_addr = AW'(int'(base) + k);
      check($sformatf("%s.addr%0d", name, k), wq[w0+k].addr, exp_addr);
      check($sformatf("%s.data%0d", name, k), wq[w0+k].data, exp_data);
      check($sformatf("%s.sat%0d", name, k), wq[w0+k].sat, sat_run);
      check($sformatf("%s.done%0d", name, k), wq[w0+k].done, k == beats.size() - 1);
      check($sformatf("%s.busy%0d", name, k), wq[w0+k].busy, k != beats.size() - 1);
    end
    check({name, ".done_once"}, done_cnt - d0, 1);
    check({name, ".done_no_write"}, done_orphan - o0, 0);
    check({name, ".sat_final"}, sat_cnt, sat_run);
    check({name, ".idle_after"}, busy, 0);
  endtask

  initial begin
    beat_t b;
    int w0;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; shift = '0; base_addr = '0;
    bus.i_valid = 1'b0; bus.in = '0;
    repeat (3) tick();
    check("rst.o_wen", bus.o_wen, 0);
    check("rst.o_addr", bus.o_addr, 0);
    check("rst.o_data", bus.o_data, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.sat_cnt", sat_cnt, 0);
    check("rst.drop", drop, 0);
    reset = 1'b0;
    tick();

    beats.delete();
    for (int k = 0; k < NIJ; k++) begin
      for (int j = 0; j < COL; j++) b[j] = k - 18;
      beats.push_back(b);
    end
    run_tile("basic", 8'h10, 1'b0, 0, 0, -1, 1'b0);

    fill_random(NIJ, 200);
    beats[0] = '{-100, -1, 0, 3, 4, 28, 31, 40};
    w0 = wq.size();
    run_tile("relu", 8'h40, 1'b1, 2, 0, -1, 1'b0);
    check("relu.first_word", wq[w0].data, 32'h7771_0000);

    fill_random(NIJ, 0);
    run_tile("gap", 8'($urandom), 1'($urandom), int'($urandom_range(15, 0)), 3, -1, 1'b0);

    w0 = wq.size();
    bus.i_valid = 1'b1; bus.in = pack(beats[0]);
    tick();
    bus.i_valid = 1'b0;
    check("idle.drop_set", drop, 1);
    repeat (2) tick();
    check("idle.no_write", wq.size() - w0, 0);
    check("idle.drop_sticky", drop, 1);
    fill_random(NIJ, 120);
    run_tile("drop", 8'h20, 1'b0, 1, 1, 5, 1'b1);
    check("drop.held_in_idle", drop, 1);

    fill_random(NIJ, 60);
    run_tile("wrap", 8'hF0, 1'b0, 3, 0, -1, 1'b0);
    check("wrap.last_addr", wq[wq.size()-1].addr, 8'h13);

    w0 = wq.size();
    fill_random(NIJ, 100);
    start = 1'b1; base_addr = 8'h80; relu_en = 1'b1; shift = 4'd1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.i_valid = 1'b1; bus.in = pack(beats[k]);
      tick();
    end
    bus.i_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.o_wen", bus.o_wen, 0);
    check("midrst.o_addr", bus.o_addr, 0);
    check("midrst.o_data", bus.o_data, 0);
    check("midrst.busy", busy, 0);
    check("midrst.done", done, 0);
    check("midrst.sat_cnt", sat_cnt, 0);
    check("midrst.drop", drop, 0);
    repeat (3) tick();
    check("midrst.writes", wq.size() - w0, 10);
    check("midrst.quiet", bus.o_wen, 0);

    fill_random(NIJ, 0);
    run_tile("fresh", 8'h55, 1'b0, int'($urandom_range(15, 0)), 2, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
